alu_seq: RTL

Operand-fetch and writeback sequencer that sits directly upstream of the 8-bit combinational ALU (A, B, 3-bit mode → out). It accepts register-to-register commands over a valid/ready handshake, reads operands from a 4-entry 8-bit register file, drives the ALU inputs, and captures the ALU result. It then writes the result back, updates zero/negative flags, and reports each writeback on a strobe.

---
 rtl/alu_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: operand-fetch / writeback sequencer in front of an 8-bit combinational ALU.
// Commands walk IDLE -> EXEC -> WB. Operands come from a 4-entry register file or an immediate.
// In EXEC the ALU output is captured. WB commits the register file write and the z/n flags.
// Optional feature macro: ALU_SEQ_BYPASS_EN. When defined, a new command can be accepted in WB,
// and WB results are forwarded to the new command's source operands.
module alu_seq #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_srca,
    input  logic [1:0]        cmd_srcb,
    input  logic              cmd_imm_en,
    input  logic [DATA_W-1:0] cmd_imm,
    input  logic [1:0]        cmd_dst,
    input  logic              ld_valid,
    input  logic [1:0]        ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_mode,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wr_valid,
    output logic [1:0]        wr_dst,
    output logic [DATA_W-1:0] wr_data,
    output logic              flag_z,
    output logic              flag_n
);

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

    state_e                  state_q, state_d;
    logic [3:0][DATA_W-1:0]  rf_q, rf_d;
    logic [DATA_W-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]              mode_q, mode_d;
    logic [1:0]              dst_q, dst_d;
    logic                    fz_q, fz_d, fn_q, fn_d;
    logic                    accept;
    logic [DATA_W-1:0]       src_a, src_b;

    // Ready decode (state only) and operand selection, reading the pre-edge register file
    always_comb begin
`ifdef ALU_SEQ_BYPASS_EN
        cmd_ready = (state_q == IDLE) || (state_q == WB);
`else
        cmd_ready = (state_q == IDLE);
`endif
        accept = cmd_valid && cmd_ready;
        src_a  = rf_q[cmd_srca];
        src_b  = cmd_imm_en ? cmd_imm : rf_q[cmd_srcb];
`ifdef ALU_SEQ_BYPASS_EN
        // The WB result is not in rf yet, so forward it. An immediate B operand is never forwarded.
        if (state_q == WB && cmd_srca == dst_q)
            src_a = res_q;
        if (state_q == WB && !cmd_imm_en && cmd_srcb == dst_q)
            src_b = res_q;
`endif
    end

    // Next-state, operand latch, result capture, register file and flag updates
    always_comb begin
        state_d = state_q;
        rf_d    = rf_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        dst_d   = dst_q;
        res_d   = res_q;
        fz_d    = fz_q;
        fn_d    = fn_q;

        // Direct loads land first so that a same-edge WB write to the same index overrides them
        if (ld_valid)
            rf_d[ld_addr] = ld_data;

        case (state_q)
            IDLE: ;
            EXEC: begin
                res_d   = alu_out;
                state_d = WB;
            end
            WB: begin
                rf_d[dst_q] = res_q;
                fz_d        = (res_q == '0);
                fn_d        = res_q[DATA_W-1];
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Accept is only possible in IDLE, or in WB when bypass is enabled
        if (accept) begin
            a_d     = src_a;
            b_d     = src_b;
            mode_d  = cmd_op;
            dst_d   = cmd_dst;
            state_d = EXEC;
        end
    end

    // State and datapath registers; reset discards any in-flight command
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rf_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            dst_q   <= '0;
            res_q   <= '0;
            fz_q    <= 1'b0;
            fn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            dst_q   <= dst_d;
            res_q   <= res_d;
            fz_q    <= fz_d;
            fn_q    <= fn_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_mode = mode_q;
    assign wr_valid = (state_q == WB);
    assign wr_dst   = dst_q;
    assign wr_data  = res_q;
    assign flag_z   = fz_q;
    assign flag_n   = fn_q;

endmodule
